// File: rtl/ip_wrapper_fifo.sv
// Bus-to-IP wrapper: a TX FIFO feeds operands to an attached IP, an RX FIFO collects its results.
// Optional interrupt output enabled by defining WRAPPER_IRQ_EN; otherwise irq is tied low.
module ip_wrapper_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              wr,
  input  logic [1:0]        HADDR,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] IPdata_in,
  output logic              write,
  input  logic              ip_ack,
  input  logic [DATA_W-1:0] IPdata_out,
  input  logic              ready,
  output logic              irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] A_TX  = 2'd0;
  localparam logic [1:0] A_RX  = 2'd1;
  localparam logic [1:0] A_ST  = 2'd2;
  localparam logic [1:0] A_CLR = 2'd3;

  function automatic logic sticky(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c, input logic push,
                                              input logic pop);
    logic [CW-1:0] r;
    r = c;
    if (push && !pop) r = c + CW'(1);
    else if (pop && !push) r = c - CW'(1);
    return r;
  endfunction

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [PW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
  logic              tx_ovf_q, rx_ovf_q, rx_udf_q;
  logic              tx_ovf_d, rx_ovf_d, rx_udf_d;
  logic [DATA_W-1:0] out_q, out_d, status;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_wr_req, tx_push, tx_pop, rx_rd_req, rx_push, rx_pop, clr_wr;

  assign tx_full   = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty  = (tx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty  = (rx_cnt_q == '0);

  assign tx_wr_req = sel & wr & (HADDR == A_TX);
  assign rx_rd_req = sel & ~wr & (HADDR == A_RX);
  assign clr_wr    = sel & wr & (HADDR == A_CLR);

  // A pop on the same edge makes room, so a full FIFO still accepts a push.
  assign tx_pop    = ~tx_empty & ip_ack;
  assign tx_push   = tx_wr_req & (~tx_full | tx_pop);
  assign rx_pop    = rx_rd_req & ~rx_empty;
  assign rx_push   = ready & (~rx_full | rx_pop);

  assign write     = ~tx_empty;
  assign IPdata_in = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign out_data  = out_q;

  always_comb begin
    status         = '0;
    status[6:0]    = 7'(tx_cnt_q);
    status[14:8]   = 7'(rx_cnt_q);
    status[16]     = tx_full;
    status[17]     = rx_empty;
    status[24]     = tx_ovf_q;
    status[25]     = rx_ovf_q;
    status[26]     = rx_udf_q;

    tx_cnt_d = cnt_next(tx_cnt_q, tx_push, tx_pop);
    rx_cnt_d = cnt_next(rx_cnt_q, rx_push, rx_pop);

    tx_ovf_d = sticky(tx_ovf_q, tx_wr_req & tx_full & ~tx_pop, clr_wr & in_data[24]);
    rx_ovf_d = sticky(rx_ovf_q, ready & rx_full & ~rx_pop,     clr_wr & in_data[25]);
    rx_udf_d = sticky(rx_udf_q, rx_rd_req & rx_empty,          clr_wr & in_data[26]);

    out_d = out_q;
    if (sel && !wr) begin
      case (HADDR)
        A_RX:    out_d = rx_empty ? '0 : rx_mem[rx_rp_q];
        A_ST:    out_d = status;
        default: out_d = '0;
      endcase
    end
  end

  // Storage arrays carry data only; pointers and counts decide validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= in_data;
    if (rx_push) rx_mem[rx_wp_q] <= IPdata_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      out_q    <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      rx_udf_q <= rx_udf_d;
      out_q    <= out_d;
    end
  end

`ifdef WRAPPER_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (rx_cnt_q != '0) | tx_ovf_q | rx_ovf_q | rx_udf_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ip_wrapper_fifo.sv
// Self-checking bench for ip_wrapper_fifo: vector table plus hand-written corner sequences,
// with queue scoreboards predicting the TX operand order and RX read-back data.
module tb_ip_wrapper_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, sel, wr, ip_ack, ready;
  logic [1:0]    HADDR;
  logic [DW-1:0] in_data, out_data, IPdata_in, IPdata_out;
  logic          write, irq;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tx_sb [$];
  logic [DW-1:0] rx_sb [$];

  typedef enum {OP_WR, OP_RD, OP_RXRD, OP_RDY, OP_ACK, OP_PEEK, OP_EMPTY, OP_HOLD} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [$];

  ip_wrapper_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .HADDR(HADDR), .in_data(in_data),
    .out_data(out_data), .IPdata_in(IPdata_in), .write(write), .ip_ack(ip_ack),
    .IPdata_out(IPdata_out), .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    sel = 1'b0; wr = 1'b0; HADDR = 2'd0; in_data = '0;
    ip_ack = 1'b0; ready = 1'b0; IPdata_out = '0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; HADDR = a; in_data = d;
    if (a == 2'd0 && tx_sb.size() < DEPTH) tx_sb.push_back(d);
    step();
    idle();
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; wr = 1'b0; HADDR = a;
    step();
    d = out_data;
    idle();
  endtask

  task automatic rdy(input logic [31:0] d);
    ready = 1'b1; IPdata_out = d;
    if (rx_sb.size() < DEPTH) rx_sb.push_back(d);
    step();
    idle();
  endtask

  task automatic rx_read(input string n);
    logic [31:0] e, got;
    e = (rx_sb.size() != 0) ? rx_sb.pop_front() : 32'h0;
    bus_rd(2'd1, got);
    chk(n, got, e);
  endtask

  task automatic ack(input string n);
    chk({n, "_write"}, {31'b0, write}, 32'd1);
    if (tx_sb.size() != 0) chk(n, IPdata_in, tx_sb.pop_front());
    else begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty, got %h", n, IPdata_in);
    end
    ip_ack = 1'b1;
    step();
    idle();
  endtask

  task automatic add(input op_e op, input logic [1:0] a, input logic [31:0] d,
                     input logic [31:0] e, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] got;
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_out", out_data, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    bus_rd(2'd2, got);
    chk("rst_status", got, 32'h0002_0000);

    add(OP_WR,    2'd0, 32'h11, 32'h0, "tx_wr1");
    add(OP_WR,    2'd0, 32'h22, 32'h0, "tx_wr2");
    add(OP_WR,    2'd0, 32'h33, 32'h0, "tx_wr3");
    add(OP_PEEK,  2'd0, 32'h0,  32'h11, "fwft_head");
    add(OP_RD,    2'd2, 32'h0,  32'h0002_0003, "status_cnt3");
    add(OP_WR,    2'd0, 32'h44, 32'h0, "tx_wr4");
    add(OP_WR,    2'd0, 32'h55, 32'h0, "tx_wr5_drop");
    add(OP_RD,    2'd2, 32'h0,  32'h0103_0004, "status_full_ovf");
    add(OP_ACK,   2'd0, 32'h0,  32'h0, "drain1");
    add(OP_ACK,   2'd0, 32'h0,  32'h0, "drain2");
    add(OP_ACK,   2'd0, 32'h0,  32'h0, "drain3");
    add(OP_ACK,   2'd0, 32'h0,  32'h0, "drain4");
    add(OP_EMPTY, 2'd0, 32'h0,  32'h0, "tx_empty");
    add(OP_RD,    2'd2, 32'h0,  32'h0102_0000, "status_drained");
    add(OP_WR,    2'd3, 32'h0100_0000, 32'h0, "clr_txovf");
    add(OP_RD,    2'd2, 32'h0,  32'h0002_0000, "status_txovf_clr");
    add(OP_RDY,   2'd0, 32'hA5, 32'h0, "rdy_a5");
    add(OP_HOLD,  2'd0, 32'h0,  32'h0002_0000, "out_hold");
    add(OP_RDY,   2'd0, 32'h5A, 32'h0, "rdy_5a");
    add(OP_RD,    2'd2, 32'h0,  32'h0000_0200, "status_rx2");
    add(OP_RXRD,  2'd1, 32'h0,  32'h0, "rx_rd_a5");
    add(OP_RXRD,  2'd1, 32'h0,  32'h0, "rx_rd_5a");
    add(OP_RXRD,  2'd1, 32'h0,  32'h0, "rx_rd_empty");
    add(OP_RD,    2'd2, 32'h0,  32'h0402_0000, "status_udf");
    add(OP_RD,    2'd3, 32'h0,  32'h0, "clear_read");
    add(OP_WR,    2'd3, 32'h0400_0000, 32'h0, "clr_udf");
    add(OP_WR,    2'd1, 32'hDEAD, 32'h0, "wr_rxdata");
    add(OP_WR,    2'd2, 32'hBEEF, 32'h0, "wr_status");
    add(OP_RD,    2'd2, 32'h0,  32'h0002_0000, "status_clean");
    add(OP_HOLD,  2'd0, 32'h0,  32'h0002_0000, "out_hold2");

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:    bus_wr(vecs[i].addr, vecs[i].data);
        OP_RD:    begin bus_rd(vecs[i].addr, got); chk(vecs[i].name, got, vecs[i].exp); end
        OP_RXRD:  rx_read(vecs[i].name);
        OP_RDY:   rdy(vecs[i].data);
        OP_ACK:   ack(vecs[i].name);
        OP_PEEK:  begin
                    chk({vecs[i].name, "_write"}, {31'b0, write}, 32'd1);
                    chk(vecs[i].name, IPdata_in, vecs[i].exp);
                  end
        OP_EMPTY: chk(vecs[i].name, {31'b0, write}, 32'd0);
        OP_HOLD:  begin step(); chk(vecs[i].name, out_data, vecs[i].exp); end
        default:  ;
      endcase
    end

    // Full TX FIFO: push and pop on one edge must both land with no overflow.
    for (int i = 1; i <= 4; i++) bus_wr(2'd0, 32'(i));
    sel = 1'b1; wr = 1'b1; HADDR = 2'd0; in_data = 32'h5; ip_ack = 1'b1;
    chk("full_pushpop_head", IPdata_in, tx_sb.pop_front());
    tx_sb.push_back(32'h5);
    step();
    idle();
    bus_rd(2'd2, got);
    chk("full_pushpop_status", got, 32'h0003_0004);
    for (int i = 0; i < 4; i++) ack("full_pushpop_drain");
    chk("full_pushpop_empty", {31'b0, write}, 32'd0);

    // RX overflow, full push+pop, and set-beats-clear on the sticky flag.
    for (int i = 0; i < 5; i++) rdy(32'hC0 + 32'(i));
    ready = 1'b1; IPdata_out = 32'h77; sel = 1'b1; wr = 1'b0; HADDR = 2'd1;
    begin
      logic [31:0] e;
      e = rx_sb.pop_front();
      rx_sb.push_back(32'h77);
      step();
      chk("rx_full_pushpop", out_data, e);
    end
    idle();
    ready = 1'b1; IPdata_out = 32'h88; sel = 1'b1; wr = 1'b1; HADDR = 2'd3;
    in_data = 32'h0200_0000;
    step();
    idle();
    bus_rd(2'd2, got);
    chk("rxovf_set_wins", got, 32'h0200_0400);
`ifndef WRAPPER_IRQ_EN
    chk("irq_off_ovf", {31'b0, irq}, 32'd0);
`endif
    bus_wr(2'd3, 32'h0200_0000);
    bus_rd(2'd2, got);
    chk("rxovf_cleared", got, 32'h0000_0400);
    for (int i = 0; i < 4; i++) rx_read("rx_drain");

    // ip_ack without a valid operand must not pop anything.
    ip_ack = 1'b1;
    step();
    idle();
    bus_wr(2'd0, 32'h99);
    bus_rd(2'd2, got);
    chk("ack_ignored_status", got, 32'h0002_0001);
    ack("ack_ignored_data");

    // Reset mid-transfer discards everything, including that edge's activity.
    bus_wr(2'd0, 32'hA1);
    bus_wr(2'd0, 32'hA2);
    rdy(32'h33);
    bus_rd(2'd2, got);
    rst = 1'b1; sel = 1'b1; wr = 1'b1; HADDR = 2'd0; in_data = 32'hEE;
    ready = 1'b1; IPdata_out = 32'h44; ip_ack = 1'b1;
    step();
    rst = 1'b0;
    idle();
    tx_sb.delete();
    rx_sb.delete();
    chk("rst_mid_write", {31'b0, write}, 32'd0);
    chk("rst_mid_ipdata", IPdata_in, 32'h0);
    chk("rst_mid_out", out_data, 32'h0);
    step();
    chk("rst_mid_write2", {31'b0, write}, 32'd0);
    bus_rd(2'd2, got);
    chk("rst_mid_status", got, 32'h0002_0000);
    bus_wr(2'd0, 32'hAB);
    ack("post_rst_word");

    // Interrupt timing: registered from the pre-edge state.
    rdy(32'h1);
    chk("irq_after_push", {31'b0, irq}, 32'd0);
    step();
`ifdef WRAPPER_IRQ_EN
    chk("irq_rx_pending", {31'b0, irq}, 32'd1);
`else
    chk("irq_off_rx", {31'b0, irq}, 32'd0);
`endif
    rx_read("irq_rx_read");
    step();
    chk("irq_cleared", {31'b0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_wrapper_fifo.md
IP_WRAPPER_FIFO -- requirements
Module: ip_wrapper_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the bus and IP data width; legal values are 32 or more.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entries per FIFO; legal values are powers of 2 from 2 to 64.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port sel, input, 1: bus access strobe, one access per cycle while high.
REQ-006 Port wr, input, 1: access direction, 1 = write, 0 = read; qualified by sel.
REQ-007 Port HADDR, input, 2: register select; 0 = TXDATA, 1 = RXDATA, 2 = STATUS, 3 = CLEAR.
REQ-008 Port in_data, input, DATA_W: bus write data.
REQ-009 Port out_data, output, DATA_W: registered bus read data.
REQ-010 Port IPdata_in, output, DATA_W: operand to the IP, equal to the TX FIFO head.
REQ-011 Port write, output, 1: operand valid to the IP, high while the TX FIFO is non-empty.
REQ-012 Port ip_ack, input, 1: the IP consumes IPdata_in when write and ip_ack are both high.
REQ-013 Port IPdata_out, input, DATA_W: result from the IP.
REQ-014 Port ready, input, 1: IPdata_out is valid this cycle; one result per high cycle.
REQ-015 Port irq, output, 1: interrupt request; present in all builds.

Function
REQ-016 A write to TXDATA (sel & wr & HADDR==0) SHALL push in_data into the TX FIFO when it is not full.
- If full, the word SHALL be dropped and sticky tx_ovf set.
REQ-017 The TX FIFO SHALL be first-word-fall-through.
- A word pushed into an empty FIFO at edge N appears on IPdata_in with write=1 after edge N.
REQ-018 TX pop SHALL occur on an edge where write & ip_ack; ip_ack with write low SHALL be ignored.
REQ-019 A simultaneous TX push and pop SHALL both take effect with the count unchanged, including when the FIFO is full.
REQ-020 ready high SHALL push IPdata_out into the RX FIFO.
- If the RX FIFO is full and no pop occurs that cycle, the word SHALL be dropped and sticky rx_ovf set.
REQ-021 A read of RXDATA (sel & ~wr & HADDR==1) SHALL load the RX head into out_data on the next edge and pop it.
- If the RX FIFO is empty, out_data SHALL load 0 and sticky rx_udf SHALL be set.
REQ-022 A simultaneous RX push and pop SHALL both take effect; a pop from a full FIFO frees space for the same-cycle push.
REQ-023 A read of STATUS SHALL load out_data on the next edge; all unlisted bits are 0:
- [6:0] tx_count
- [14:8] rx_count
- [16] tx_full
- [17] rx_empty
- [24] tx_ovf
- [25] rx_ovf
- [26] rx_udf
REQ-024 A read of CLEAR SHALL load out_data with 0.
REQ-025 A write to CLEAR SHALL clear each sticky flag whose bit (24/25/26) in in_data is 1.
- If a set event and a clear hit the same flag on the same edge, the set SHALL win.
REQ-026 Writes to RXDATA or STATUS SHALL have no effect.
REQ-027 out_data SHALL hold its value on every cycle without a bus read.
REQ-028 FIFO pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-029 While rst is high at an edge, the block SHALL clear both FIFOs, counts and sticky flags, and set out_data=0, write=0, irq=0.
- Bus and IP activity on that edge is ignored.
REQ-030 Reset asserted mid-transfer SHALL discard all queued words; no word SHALL appear on IPdata_in after reset until a new TXDATA write.

Configuration
REQ-031 When WRAPPER_IRQ_EN is defined, irq SHALL be a register updated each edge to (rx_count != 0) | tx_ovf | rx_ovf | rx_udf.
REQ-032 When WRAPPER_IRQ_EN is not defined, irq SHALL be constant 0 and no interrupt logic SHALL be synthesised.

Verification
REQ-033 Reset, then TXDATA writes 0x11, 0x22, 0x33 with ip_ack=0 -> write=1, IPdata_in=0x11; STATUS reads tx_count=3.
REQ-034 DEPTH=4 with 5 TXDATA writes and no ack -> tx_full=1, tx_ovf=1; acks drain exactly 4 words in order.
REQ-035 ready pulses with 0xA5 then 0x5A, then two RXDATA reads -> out_data 0xA5 then 0x5A; a third read -> out_data=0 and rx_udf=1.
REQ-036 TX FIFO full with a TXDATA write and write&ip_ack on the same edge -> no overflow, tx_count stays 4, order preserved.
REQ-037 Sticky rx_ovf set; CLEAR write 0x0200_0000 on the same edge as a new overflow -> flag stays 1; a CLEAR write alone -> flag clears.
REQ-038 With WRAPPER_IRQ_EN, one ready pulse -> irq=1 on the following edge; one RXDATA read -> irq=0 on the following edge; without the macro, irq stays 0 throughout.
